memarb: RTL and testbench
=========================

# memarb

Two-requester arbiter that shares the single-ported data memory between the instruction-fetch path and the load/store path of the 64-bit MIPS core. It latches each request, drives the memory through a req/ack handshake, returns the 32-bit instruction or data word with a one-cycle valid pulse, and holds the losing requester stalled. It sits between the core's fetch/memory stages and the memory model. A timeout guards against a memory that never acknowledges.

## Interface
- N, 64, data/address width of the data port and memory bus
- TO, 31, cycles in a grant state without m_ack before timeout (1..255)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- ireq  in  1  fetch request; held high until ival
- iadr  in  32  fetch byte address
- instr  out  32  fetched instruction, valid when ival
- ival  out  1  one-cycle fetch completion pulse
- istall  out  1  ireq & ~ival
- dreq  in  1  data request; held high until dval
- dwrite  in  2  0 read, 1 word write, 2 byte write, 3 doubleword write
- dadr  in  N  data byte address
- dwdata  in  N  write data
- drdata  out  N  {32'b0, selected word} for reads, 0 for writes; valid when dval
- dval  out  1  one-cycle data completion pulse
- dstall  out  1  dreq & ~dval
- m_req  out  1  memory request, registered
- m_write  out  2  write code to memory (0 for fetches)
- m_adr  out  N  memory byte address (fetch: zero-extended iadr)
- m_wdata  out  N  memory write data
- m_rdata  in  N  memory read doubleword, valid with m_ack
- m_ack  in  1  memory completion
- err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, GNT_I, GNT_D, RESP.
- IDLE: dreq only -> GNT_D; ireq only -> GNT_I; both -> grant opposite of last-granted flag `last`, then update `last`.
- On grant edge: latch address, write code, write data into m_* registers; clear timeout counter.
- GNT_*: m_req=1, m_* stable; m_ack=1 -> capture result, RESP. Counter increments each cycle without ack; reaching TO -> RESP with result 0, err<=1.
- Word select: adr[2]=0 -> m_rdata[63:32], adr[2]=1 -> m_rdata[31:0] (big-endian word order).
- RESP: ival or dval=1 for the granted side, instr/drdata hold captured value until next RESP; next state IDLE.
- Request inputs are sampled only in IDLE; changes during GNT_*/RESP are ignored. A req still high in the cycle after val is a new request.
- m_ack outside GNT_* ignored.

## Timing
- Reset values: state IDLE, `last`=I (so first contention grants D), m_req=0, m_write=0, m_adr=0, m_wdata=0, instr=0, drdata=0, ival=0, dval=0, err=0.
- Minimum latency: req sampled in IDLE cycle 0, m_req high cycle 1, m_ack in cycle 1 -> val in cycle 2.
- Memory with fixed latency L (ack L cycles after m_req rises): val at cycle L+2.
- Back-to-back: one IDLE cycle between RESP and next grant; contending requesters alternate I/D/I/D.
- Timeout: no ack for TO cycles in grant -> RESP at grant-cycle TO+1, val pulses, result 0, err stays 1 until reset.
- m_ack coinciding with counter reaching TO: ack wins, err unchanged.
- Reset mid-transaction: m_req and val drop immediately (asynchronous); pending requests re-arbitrate from IDLE after reset release.

## Test plan
- Single fetch, iadr=0x04, memory acks 20 cycles later with m_rdata=0x20020005_2003000C -> ival at cycle 22, instr=0x2003000C, istall high cycles 0..21.
- Single read dadr=0x10, ack in same cycle, m_rdata=0xAAAA_BBBB_CCCC_DDDD -> dval at cycle 2, drdata=0x00000000_AAAABBBB.
- ireq and dreq both high from reset, ack after 3 cycles each -> D granted first, then I; subsequent contention alternates D,I,D,I; m_write=3 with dwrite=3.
- Byte write dwrite=2, dadr=0x23, dwdata=0xFF -> m_write=2, m_adr=0x23, m_wdata=0xFF during grant; dval, drdata=0.
- No ack ever, TO=31 -> val at cycle 32 after grant, result 0, err=1 persisting; next request served normally.
- Assert reset while m_req=1 -> m_req=0 immediately, no val pulse, err=0; after release, held ireq re-served.

Source files
------------

// File: rtl/memarb.sv
// Two-requester arbiter sharing one memory port between instruction fetch and load/store.
// Each request is latched, driven through a req/ack handshake and answered with a one-cycle valid pulse.
module memarb #(
    parameter int N  = 64,
    parameter int TO = 31
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ireq,
    input  logic [31:0]  iadr,
    output logic [31:0]  instr,
    output logic         ival,
    output logic         istall,
    input  logic         dreq,
    input  logic [1:0]   dwrite,
    input  logic [N-1:0] dadr,
    input  logic [N-1:0] dwdata,
    output logic [N-1:0] drdata,
    output logic         dval,
    output logic         dstall,
    output logic         m_req,
    output logic [1:0]   m_write,
    output logic [N-1:0] m_adr,
    output logic [N-1:0] m_wdata,
    input  logic [N-1:0] m_rdata,
    input  logic         m_ack,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state_q;
    logic           last_d_q;      // 1 when the most recent grant went to the data side
    logic [7:0]     cnt_q;
    logic           m_req_q;
    logic [1:0]     m_write_q;
    logic [N-1:0]   m_adr_q;
    logic [N-1:0]   m_wdata_q;
    logic [31:0]    instr_q;
    logic [N-1:0]   drdata_q;
    logic           ival_q;
    logic           dval_q;
    logic           err_q;

    logic [31:0]    word_d;
    logic           pick_d_d;
    logic           timeout_d;

    always_comb begin
        // Big-endian word order within the returned doubleword
        word_d    = m_adr_q[2] ? m_rdata[31:0] : m_rdata[63:32];
        pick_d_d  = dreq & (~ireq | ~last_d_q);
        timeout_d = (cnt_q == 8'(TO - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            cnt_q     <= '0;
            m_req_q   <= 1'b0;
            m_write_q <= '0;
            m_adr_q   <= '0;
            m_wdata_q <= '0;
            instr_q   <= '0;
            drdata_q  <= '0;
            ival_q    <= 1'b0;
            dval_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ival_q <= 1'b0;
            dval_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ireq | dreq) begin
                        m_req_q  <= 1'b1;
                        cnt_q    <= '0;
                        last_d_q <= pick_d_d;
                        if (pick_d_d) begin
                            state_q   <= GNT_D;
                            m_write_q <= dwrite;
                            m_adr_q   <= dadr;
                            m_wdata_q <= dwdata;
                        end else begin
                            state_q   <= GNT_I;
                            m_write_q <= 2'd0;
                            m_adr_q   <= {{(N-32){1'b0}}, iadr};
                            m_wdata_q <= '0;
                        end
                    end
                end
                GNT_I, GNT_D: begin
                    if (m_ack) begin
                        m_req_q <= 1'b0;
                        state_q <= RESP;
                        if (state_q == GNT_I) begin
                            instr_q <= word_d;
                            ival_q  <= 1'b1;
                        end else begin
                            drdata_q <= (m_write_q == 2'd0) ? {{(N-32){1'b0}}, word_d} : '0;
                            dval_q   <= 1'b1;
                        end
                    end else if (timeout_d) begin
                        // Memory never answered: complete with a zero result and flag it
                        m_req_q <= 1'b0;
                        state_q <= RESP;
                        err_q   <= 1'b1;
                        if (state_q == GNT_I) begin
                            instr_q <= '0;
                            ival_q  <= 1'b1;
                        end else begin
                            drdata_q <= '0;
                            dval_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign instr   = instr_q;
    assign ival    = ival_q;
    assign drdata  = drdata_q;
    assign dval    = dval_q;
    assign m_req   = m_req_q;
    assign m_write = m_write_q;
    assign m_adr   = m_adr_q;
    assign m_wdata = m_wdata_q;
    assign err     = err_q;
    assign istall  = ireq & ~ival_q;
    assign dstall  = dreq & ~dval_q;

endmodule

// File: tb/tb_memarb.sv
// Randomized bench for memarb: a transaction-level model predicts winner, bus fields, latency and results.
module tb_memarb;
    localparam int N  = 64;
    localparam int TO = 31;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ireq = 1'b0;
    logic [31:0]  iadr = '0;
    logic [31:0]  instr;
    logic         ival, istall;
    logic         dreq = 1'b0;
    logic [1:0]   dwrite = '0;
    logic [N-1:0] dadr = '0;
    logic [N-1:0] dwdata = '0;
    logic [N-1:0] drdata;
    logic         dval, dstall;
    logic         m_req;
    logic [1:0]   m_write;
    logic [N-1:0] m_adr, m_wdata;
    logic [N-1:0] m_rdata = '0;
    logic         m_ack = 1'b0;
    logic         err;

    memarb #(.N(N), .TO(TO)) dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iadr(iadr), .instr(instr), .ival(ival), .istall(istall),
        .dreq(dreq), .dwrite(dwrite), .dadr(dadr), .dwdata(dwdata),
        .drdata(drdata), .dval(dval), .dstall(dstall),
        .m_req(m_req), .m_write(m_write), .m_adr(m_adr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;
    int txn_no = 0;

    // Reference state
    bit          last_i = 1'b1;
    bit          err_exp = 1'b0;
    logic [31:0] instr_exp = '0;
    logic [63:0] drdata_exp = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sel_word(input logic [63:0] adr, input logic [63:0] rd);
        return adr[2] ? rd[31:0] : rd[63:32];
    endfunction

    // Starts on the falling edge of an IDLE cycle; lat = cycles from m_req rise to ack, <0 = never
    task automatic run_txn(input bit wi, input bit wd, input int lat,
                           input logic [31:0] ia, input logic [63:0] da,
                           input logic [1:0] dw, input logic [63:0] dwd, input logic [63:0] rd);
        bit          win_d, timed_out;
        int          valc;
        logic [1:0]  ew;
        logic [63:0] ea, ewd;
        logic [31:0] word;
        if (wi && !ireq) begin ireq = 1'b1; iadr = ia; end
        if (wd && !dreq) begin dreq = 1'b1; dadr = da; dwrite = dw; dwdata = dwd; end
        win_d  = dreq && (!ireq || last_i);
        last_i = !win_d;
        if (win_d) begin ew = dwrite; ea = dadr; ewd = dwdata; end
        else begin ew = 2'd0; ea = {32'b0, iadr}; ewd = '0; end
        timed_out = (lat < 0) || (lat >= TO);
        valc = timed_out ? TO + 1 : lat + 2;
        chk("hold_instr", {32'b0, instr}, {32'b0, instr_exp});
        chk("hold_drdata", drdata, drdata_exp);
        chk("idle_mreq", {63'b0, m_req}, 64'd0);
        @(posedge clk); @(negedge clk);
        for (int k = 1; k < valc; k++) begin
            if (k == 1 || k == valc - 1) begin
                chk("gnt_mreq", {63'b0, m_req}, 64'd1);
                chk("gnt_mwrite", {62'b0, m_write}, {62'b0, ew});
                chk("gnt_madr", m_adr, ea);
                chk("gnt_mwdata", m_wdata, ewd);
                chk("gnt_noval", {62'b0, ival, dval}, 64'd0);
                chk("gnt_stall", {62'b0, istall, dstall}, {62'b0, ireq, dreq});
            end
            m_ack   = (k - 1 == lat);
            m_rdata = m_ack ? rd : {$urandom, $urandom};
            @(posedge clk); @(negedge clk);
        end
        // RESP cycle: a stray ack here must be ignored
        m_ack   = 1'($urandom_range(0, 1));
        m_rdata = {$urandom, $urandom};
        word = timed_out ? 32'd0 : sel_word(ea, rd);
        if (timed_out) err_exp = 1'b1;
        if (win_d) drdata_exp = (ew == 2'd0) ? {32'b0, word} : 64'd0;
        else instr_exp = word;
        chk("resp_val", {62'b0, ival, dval}, {62'b0, !win_d, win_d});
        chk("resp_instr", {32'b0, instr}, {32'b0, instr_exp});
        chk("resp_drdata", drdata, drdata_exp);
        chk("resp_err", {63'b0, err}, {63'b0, err_exp});
        chk("resp_mreq", {63'b0, m_req}, 64'd0);
        chk("resp_stall", {62'b0, istall, dstall}, {62'b0, ireq && win_d, dreq && !win_d});
        $display("txn %0d: grant=%s lat=%0d val_cycle=%0d timeout=%0b word=%h",
                 txn_no, win_d ? "D" : "I", lat, valc, timed_out, word);
        txn_no++;
        if (win_d) dreq = 1'b0; else ireq = 1'b0;
        @(posedge clk); @(negedge clk);
        m_ack = 1'b0;
        chk("pulse_end", {62'b0, ival, dval}, 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        #1;
        chk("async_reset_mreq", {63'b0, m_req}, 64'd0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_outs", {59'b0, m_req, ival, dval, err, 1'b0}, 64'd0);
        chk("rst_mwrite", {62'b0, m_write}, 64'd0);
        chk("rst_madr", m_adr, 64'd0);
        chk("rst_mwdata", m_wdata, 64'd0);
        chk("rst_instr", {32'b0, instr}, 64'd0);
        chk("rst_drdata", drdata, 64'd0);
        reset = 1'b0;

        // Contention from reset: D first (doubleword write), then alternation
        run_txn(1, 1, 3, 32'h100, 64'h48, 2'd3, 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444);
        run_txn(1, 1, 3, 32'h0, 64'h58, 2'd0, 64'h0, 64'h5555_6666_7777_8888);
        run_txn(1, 1, 0, 32'h204, 64'h0, 2'd0, 64'h0, 64'h9999_AAAA_BBBB_CCCC);
        run_txn(1, 1, 2, 32'h0, 64'h0, 2'd0, 64'h0, 64'hDDDD_EEEE_FFFF_0000);
        run_txn(0, 0, 1, 32'h0, 64'h0, 2'd0, 64'h0, 64'h1357_9BDF_2468_ACE0);

        // Directed single transactions
        run_txn(1, 0, 20, 32'h04, 64'h0, 2'd0, 64'h0, 64'h2002_0005_2003_000C);
        run_txn(0, 1, 0, 32'h0, 64'h10, 2'd0, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD);
        run_txn(0, 1, 1, 32'h0, 64'h23, 2'd2, 64'hFF, 64'hDEAD_BEEF_CAFE_F00D);
        run_txn(1, 0, TO - 1, 32'h0C, 64'h0, 2'd0, 64'h0, 64'h0BAD_F00D_1234_5678);
        run_txn(0, 1, -1, 32'h0, 64'h30, 2'd0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_txn(1, 0, 0, 32'h08, 64'h0, 2'd0, 64'h0, 64'h7654_3210_FEDC_BA98);

        // Reset while a fetch is in flight; the held request is served again afterwards
        ireq = 1'b1; iadr = 32'h40;
        @(posedge clk); @(negedge clk);
        chk("pre_rst_mreq", {63'b0, m_req}, 64'd1);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_mreq", {63'b0, m_req}, 64'd0);
        chk("mid_rst_val_err", {61'b0, ival, dval, err}, 64'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        last_i = 1'b1; err_exp = 1'b0; instr_exp = '0; drdata_exp = '0;
        run_txn(1, 0, 2, 32'h0, 64'h0, 2'd0, 64'h0, 64'h4444_3333_2222_1111);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            int sel, lat;
            sel = $urandom_range(0, 2);
            lat = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, 7);
            run_txn(sel != 1, sel != 0, lat, $urandom, {$urandom, $urandom},
                    2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom});
        end
        // Drain any request left pending by the last contention
        if (ireq || dreq) run_txn(0, 0, 0, 32'h0, 64'h0, 2'd0, 64'h0, {$urandom, $urandom});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
